// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the RAM arbiter, the RAM model and the top level.
package mem_arb_pkg;

    localparam int unsigned ARB_A = 12;
    localparam int unsigned ARB_D = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_rdpipe.sv
// Read-return pipe: remembers who owns the in-flight RAM read and steers the
// registered RAM data back to that requester one cycle after its grant.
module mem_arb_rdpipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned D = ARB_D
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  owner_t       rd_owner_i,
    input  logic [D-1:0] ram_rdata_i,
    output logic         cpu_rvalid_o,
    output logic [D-1:0] cpu_rdata_o,
    output logic         vid_rvalid_o,
    output logic [D-1:0] vid_rdata_o
);

    owner_t       owner_q;
    logic [D-1:0] cpu_rdata_q;
    logic [D-1:0] vid_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q     <= OWN_NONE;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            owner_q <= rd_owner_i;
            if (owner_q == OWN_CPU) cpu_rdata_q <= ram_rdata_i;
            if (owner_q == OWN_VID) vid_rdata_q <= ram_rdata_i;
        end
    end

    // RAM data is live only in the return cycle; the hold registers cover the rest.
    always_comb begin
        cpu_rvalid_o = (owner_q == OWN_CPU);
        vid_rvalid_o = (owner_q == OWN_VID);
        cpu_rdata_o  = cpu_rvalid_o ? ram_rdata_i : cpu_rdata_q;
        vid_rdata_o  = vid_rvalid_o ? ram_rdata_i : vid_rdata_q;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU and the VGA fetcher (urgent video, else round-robin).
// Optional `STARVE_GUARD_EN forces a pending CPU request in after MAX_VID_RUN video grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned A           = ARB_A,
    parameter int unsigned D           = ARB_D,
    parameter int unsigned MAX_VID_RUN = 8
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [A-1:0] cpu_addr,
    input  logic [D-1:0] cpu_wdata,
    output logic         cpu_gnt,
    output logic         cpu_rvalid,
    output logic [D-1:0] cpu_rdata,
    input  logic         vid_req,
    input  logic         vid_urgent,
    input  logic [A-1:0] vid_addr,
    output logic         vid_gnt,
    output logic         vid_rvalid,
    output logic [D-1:0] vid_rdata,
    output logic         ram_cs,
    output logic         ram_we,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_wdata,
    input  logic [D-1:0] ram_rdata
);

    if (MAX_VID_RUN < 1) begin : g_bad_cfg
        $error("mem_arbiter: MAX_VID_RUN must be at least 1");
    end

    owner_t rr_last_q, rr_last_d;
    owner_t rd_owner;
    logic   cpu_win, vid_win;
    logic   starve;

`ifdef STARVE_GUARD_EN
    localparam int unsigned RUN_W = $clog2(MAX_VID_RUN + 1);

    logic [RUN_W-1:0] vid_run_q, vid_run_d;

    assign starve = (vid_run_q == RUN_W'(MAX_VID_RUN));

    always_comb begin
        vid_run_d = '0;
        if (vid_win) begin
            vid_run_d = starve ? vid_run_q : vid_run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) vid_run_q <= '0;
        else          vid_run_q <= vid_run_d;
    end
`else
    assign starve = 1'b0;
`endif

    // Grants are masked during reset so nothing reaches the RAM while it is held.
    always_comb begin
        cpu_win = 1'b0;
        vid_win = 1'b0;
        if (reset_l) begin
            if (cpu_req && !vid_req) begin
                cpu_win = 1'b1;
            end else if (vid_req && !cpu_req) begin
                vid_win = 1'b1;
            end else if (cpu_req && vid_req) begin
                if (starve)                     cpu_win = 1'b1;
                else if (vid_urgent)            vid_win = 1'b1;
                else if (rr_last_q == OWN_VID)  cpu_win = 1'b1;
                else                            vid_win = 1'b1;
            end
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (cpu_win)      rr_last_d = OWN_CPU;
        else if (vid_win) rr_last_d = OWN_VID;

        rd_owner = OWN_NONE;
        if (cpu_win && !cpu_we) rd_owner = OWN_CPU;
        else if (vid_win)       rd_owner = OWN_VID;

        cpu_gnt   = cpu_win;
        vid_gnt   = vid_win;
        ram_cs    = cpu_win | vid_win;
        ram_we    = cpu_win & cpu_we;
        ram_addr  = vid_win ? vid_addr : cpu_addr;
        ram_wdata = cpu_wdata;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) rr_last_q <= OWN_VID;
        else          rr_last_q <= rr_last_d;
    end

    mem_arb_rdpipe #(
        .D (D)
    ) u_rdpipe (
        .clk_i        (clk),
        .rst_ni       (reset_l),
        .rd_owner_i   (rd_owner),
        .ram_rdata_i  (ram_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .vid_rvalid_o (vid_rvalid),
        .vid_rdata_o  (vid_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle registered-read RAM.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned A = 12;
    localparam int unsigned D = 16;

    logic         clk, reset_l;
    logic         cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [A-1:0] cpu_addr;
    logic [D-1:0] cpu_wdata, cpu_rdata;
    logic         vid_req, vid_urgent, vid_gnt, vid_rvalid;
    logic [A-1:0] vid_addr;
    logic [D-1:0] vid_rdata;
    logic         ram_cs, ram_we;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_wdata, ram_rdata;

    logic [D-1:0] mem [0:(1<<A)-1];

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(
        .A           (A),
        .D           (D),
        .MAX_VID_RUN (8)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_urgent (vid_urgent),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    function automatic logic [D-1:0] pat(input logic [A-1:0] a);
        return D'(a) * 16'd7 + 16'h1111;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        vid_req    = 1'b0;
        vid_urgent = 1'b0;
    endtask

    // Ends on a negedge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        reset_l = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << A); i++) mem[i] = pat(A'(i));
        ram_rdata = '0;
        reset_l   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vid_addr  = '0;
        idle_inputs();

        // 1: reset holds everything quiet while requests toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_req = i[0];
            vid_req = i[1];
            #1;
            check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
            check("rst_vid_gnt", 32'(vid_gnt), 32'd0);
            check("rst_ram_cs", 32'(ram_cs), 32'd0);
            check("rst_rvalid", 32'({cpu_rvalid, vid_rvalid}), 32'd0);
            check("rst_rdata", 32'({cpu_rdata, vid_rdata}), 32'd0);
        end
        @(negedge clk);
        reset_l  = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 12'h000;
        vid_req  = 1'b0;
        #1;
        check("first_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("first_ram_cs", 32'(ram_cs), 32'd1);

        // 2: CPU write then read back
        @(negedge clk);
        cpu_we    = 1'b1;
        cpu_addr  = 12'h005;
        cpu_wdata = 16'h1234;
        #1;
        check("wr_gnt", 32'(cpu_gnt), 32'd1);
        check("wr_ram_we", 32'(ram_we), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'h005);
        check("wr_ram_wdata", 32'(ram_wdata), 32'h1234);
        check("first_rvalid", 32'(cpu_rvalid), 32'd1);
        check("first_rdata", 32'(cpu_rdata), 32'h1111);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        check("rd_gnt", 32'(cpu_gnt), 32'd1);
        check("rd_ram_we", 32'(ram_we), 32'd0);
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_rdata", 32'(cpu_rdata), 32'h1234);
        check("idle_cs", 32'(ram_cs), 32'd0);
        @(negedge clk);
        #1;
        check("hold_rvalid", 32'(cpu_rvalid), 32'd0);
        check("hold_rdata", 32'(cpu_rdata), 32'h1234);

        // 3: round-robin, CPU first after reset
        do_reset();
        cpu_req  = 1'b1;
        cpu_addr = 12'h010;
        vid_req  = 1'b1;
        vid_addr = 12'h020;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_cpu_gnt", 32'(cpu_gnt), 32'(k % 2 == 0));
            check("rr_vid_gnt", 32'(vid_gnt), 32'(k % 2 == 1));
            if (k > 0) begin
                check("rr_cpu_rvalid", 32'(cpu_rvalid), 32'(k % 2 == 1));
                check("rr_vid_rvalid", 32'(vid_rvalid), 32'(k % 2 == 0));
                if (k % 2 == 1) check("rr_cpu_rdata", 32'(cpu_rdata), 32'(pat(12'h010)));
                else            check("rr_vid_rdata", 32'(vid_rdata), 32'(pat(12'h020)));
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        check("rr_last_vid_rvalid", 32'(vid_rvalid), 32'd1);
        check("rr_last_vid_rdata", 32'(vid_rdata), 32'(pat(12'h020)));

        // 4: urgent video against a held CPU request
        do_reset();
        cpu_req    = 1'b1;
        vid_req    = 1'b1;
        vid_urgent = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic exp_cpu;
`ifdef STARVE_GUARD_EN
            exp_cpu = (k % 9 == 8);
`else
            exp_cpu = 1'b0;
`endif
            #1;
            check("urg_cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu));
            check("urg_vid_gnt", 32'(vid_gnt), 32'(!exp_cpu));
            @(negedge clk);
        end
        idle_inputs();

        // 5: reset right after a read grant drops the return
        do_reset();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 12'h005;
        #1;
        check("abort_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk);
        #1;
        reset_l = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("abort_rvalid", 32'(cpu_rvalid), 32'd0);
        check("abort_owner", 32'(dut.u_rdpipe.owner_q), 32'(OWN_NONE));
        @(negedge clk);
        reset_l = 1'b1;
        #1;
        check("abort_rvalid_after", 32'({cpu_rvalid, vid_rvalid}), 32'd0);
        check("abort_rdata", 32'(cpu_rdata), 32'd0);

        // 6: back-to-back video burst
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            vid_req  = 1'b1;
            vid_addr = 12'h100 + A'(k);
            #1;
            check("burst_gnt", 32'(vid_gnt), 32'd1);
            check("burst_addr", 32'(ram_addr), 32'(12'h100 + A'(k)));
            if (k > 0) begin
                check("burst_rvalid", 32'(vid_rvalid), 32'd1);
                check("burst_rdata", 32'(vid_rdata), 32'(pat(12'h100 + A'(k - 1))));
            end
            @(negedge clk);
        end
        vid_req = 1'b0;
        #1;
        check("burst_last_rvalid", 32'(vid_rvalid), 32'd1);
        check("burst_last_rdata", 32'(vid_rdata), 32'(pat(12'h10F)));
        check("burst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        @(negedge clk);
        #1;
        check("burst_end_rvalid", 32'(vid_rvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
